cp0_ctrl: RTL
=============

CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 SHALL provide: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL provide: reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL provide: A1  in  5  mfc0 read register number.
REQ-004 SHALL provide: A2  in  5  mtc0 write register number.
REQ-005 SHALL provide: DIn  in  32  mtc0 write data.
REQ-006 SHALL provide: we  in  1  mtc0 write enable.
REQ-007 SHALL provide: M_pc  in  32  PC of the instruction in the exception stage.
REQ-008 SHALL provide: BD  in  1  that instruction is in a branch delay slot.
REQ-009 SHALL provide: ExcCode_in  in  5  synchronous exception code, 0 = none.
REQ-010 SHALL provide: HWInt  in  6  external interrupt lines, level-sensitive.
REQ-011 SHALL provide: eret  in  1  eret executing in exception stage.
REQ-012 SHALL provide: Req  out  1  redirect fetch to handler 0x0000_4180 this cycle.
REQ-013 SHALL provide: EPC  out  32  return address for eret.
REQ-014 SHALL provide: DOut  out  32  mfc0 read data.

Function
REQ-015 SHALL implement SR (reg 12): IM = bits 15:10, EXL = bit 1, IE = bit 0; other bits read 0.
REQ-016 SHALL implement Cause (reg 13): BD = bit 31, IP = bits 15:10, ExcCode = bits 6:2; other bits read 0; Cause not writable by mtc0.
REQ-017 SHALL implement EPC (reg 14), all 32 bits writable by mtc0.
REQ-018 SHALL compute IntReq = |(IP_next & IM) & IE & !EXL, where IP_next = HWInt (timer-ORed per REQ-031), combinationally.
REQ-019 SHALL compute ExcReq = (ExcCode_in != 0) & !EXL, combinationally.
REQ-020 SHALL drive Req = IntReq | ExcReq with zero-cycle latency.
REQ-021 SHALL on Req at the clock edge: EXL <= 1; Cause.BD <= BD; EPC <= BD ? M_pc - 4 : M_pc (32-bit wrap); Cause.ExcCode <= IntReq ? 0 : ExcCode_in (interrupt wins).
REQ-022 SHALL load Cause.IP from IP_next every cycle regardless of Req/EXL.
REQ-023 SHALL clear EXL at the edge when eret = 1 and Req = 0; Req = 1 takes priority over eret.
REQ-024 SHALL perform mtc0 writes to SR/EPC only when we = 1 and Req = 0; Req discards the write.
REQ-025 SHALL drive EPC output = DIn when we = 1 and A2 = 14, else the EPC register (write forwarding for eret).
REQ-026 SHALL drive DOut combinationally from A1; unimplemented register numbers read 0.
REQ-027 SHALL, with EXL = 1, suppress all new Req regardless of HWInt or ExcCode_in.

Reset
REQ-028 SHALL on reset = 0 clear SR, Cause, EPC (and Count/Compare/TI if present) to 0 immediately, independent of clk.
REQ-029 SHALL drive Req = 0 while reset = 0; reset mid-handler clears EXL.

Configuration
REQ-030 SHALL use macro CP0_COUNT_EN to include a timer: Count (reg 9) increments by 1 every cycle, wraps at 2^32; Compare (reg 11) mtc0-writable; both readable via DOut.
REQ-031 SHALL, with CP0_COUNT_EN, set sticky TI when Count == Compare and Compare != 0; clear TI on mtc0 write to Compare; IP_next[5] = HWInt[5] | TI; mtc0 to Count loads DIn.
REQ-032 SHALL, without CP0_COUNT_EN, read regs 9/11 as 0, ignore writes to them, and use IP_next = HWInt.

Verification
REQ-033 Reset: reset = 0 mid-run -> SR, Cause, EPC, DOut(A1=12) = 0 and Req = 0 before next edge.
REQ-034 Exception: SR = 0, ExcCode_in = 10, M_pc = 0x3010, BD = 1 -> Req = 1 same cycle; next cycle EPC = 0x300C, Cause = 0x8000_0028, SR.EXL = 1.
REQ-035 Interrupt: mtc0 SR = 0x0000_0401, HWInt = 6'b000001 -> Req = 1, Cause.ExcCode = 0; with ExcCode_in = 4 same cycle, ExcCode still 0.
REQ-036 Nesting/eret: EXL = 1, HWInt = 6'b111111 -> Req = 0; eret = 1 -> EXL = 0 next cycle, Req = 1 the following cycle.
REQ-037 Collision: we = 1, A2 = 14, DIn = 0x5000, Req = 1 same cycle -> EPC register = M_pc, not 0x5000; without Req, EPC output = 0x5000 that cycle.
REQ-038 Timer (CP0_COUNT_EN): Compare = 20, SR = 0x0000_8001 -> Req asserts when Count reaches 20; write Compare clears Cause.IP[15].

Source files
------------

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: MIPS-style coprocessor 0 with SR, Cause and EPC, interrupt and
// exception request generation, eret handling and mtc0/mfc0 access.
// Optional timer (Count reg 9, Compare reg 11, sticky TI on HWInt[5]) is
// built only when the CP0_COUNT_EN macro is defined.
// Ports:
//   clk, reset (async, active-low)
//   A1 mfc0 read reg, DOut read data
//   A2/DIn/we mtc0 write port
//   M_pc/BD/ExcCode_in exception-stage instruction info
//   HWInt interrupt lines, eret return strobe
//   Req handler redirect, EPC return address (write-forwarded)
module cp0_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        we,
  input  logic [31:0] M_pc,
  input  logic        BD,
  input  logic [4:0]  ExcCode_in,
  input  logic [5:0]  HWInt,
  input  logic        eret,
  output logic        Req,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  // SR fields
  logic [5:0]  im;
  logic        exl;
  logic        ie;
  // Cause fields
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  // EPC register
  logic [31:0] epc_q;

  logic [5:0]  ip_next;
  logic        int_req;
  logic        exc_req;
  logic        wr_en;
  logic        wr_sr;
  logic        wr_epc;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic [31:0] epc_target;

`ifdef CP0_COUNT_EN
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        ti;
  logic        ti_hit;
  logic        wr_count;
  logic        wr_compare;

  // Match is seen the same cycle Count reaches Compare; TI holds it after.
  assign ti_hit     = (count_q == compare_q) && (compare_q != 32'd0);
  assign wr_count   = wr_en && (A2 == REG_COUNT);
  assign wr_compare = wr_en && (A2 == REG_COMPARE);
  assign ip_next    = {HWInt[5] | ti | ti_hit, HWInt[4:0]};
`else
  assign ip_next    = HWInt;
`endif

  assign int_req = (|(ip_next & im)) && ie && !exl;
  assign exc_req = (ExcCode_in != 5'd0) && !exl;

  // Gate with reset: while held, ExcCode_in alone must not raise Req.
  assign Req = (int_req || exc_req) && reset;

  // A taken request discards any mtc0 in the same cycle.
  assign wr_en  = we && !Req;
  assign wr_sr  = wr_en && (A2 == REG_SR);
  assign wr_epc = wr_en && (A2 == REG_EPC);

  assign epc_target = BD ? (M_pc - 32'd4) : M_pc;

  // Forward an in-flight mtc0 EPC so an eret right behind it sees it.
  assign EPC = (we && (A2 == REG_EPC)) ? DIn : epc_q;

  assign sr_word    = {16'd0, im, 8'd0, exl, ie};
  assign cause_word = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};

  always_comb begin
    DOut = 32'd0;
    case (A1)
      REG_SR:      DOut = sr_word;
      REG_CAUSE:   DOut = cause_word;
      REG_EPC:     DOut = epc_q;
`ifdef CP0_COUNT_EN
      REG_COUNT:   DOut = count_q;
      REG_COMPARE: DOut = compare_q;
`endif
      default:     DOut = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im       <= 6'd0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= 6'd0;
      exc_code <= 5'd0;
      epc_q    <= 32'd0;
    end else begin
      ip <= ip_next;
      if (Req) begin
        exl      <= 1'b1;
        bd       <= BD;
        epc_q    <= epc_target;
        exc_code <= int_req ? 5'd0 : ExcCode_in;
      end else begin
        if (wr_sr) begin
          im  <= DIn[15:10];
          exl <= DIn[1];
          ie  <= DIn[0];
        end
        if (wr_epc)
          epc_q <= DIn;
        if (eret)
          exl <= 1'b0;
      end
    end
  end

`ifdef CP0_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      ti        <= 1'b0;
    end else begin
      if (wr_count)
        count_q <= DIn;
      else
        count_q <= count_q + 32'd1;
      if (wr_compare)
        compare_q <= DIn;
      if (wr_compare)
        ti <= 1'b0;
      else if (ti_hit)
        ti <= 1'b1;
    end
  end
`endif

endmodule
